// File: rtl/arp_reply_resolver_if.sv
// ARP resolver bus: rx byte stream, lookup request and resolution status.
// Latency: none, this is only a signal bundle.
// Backpressure: none; the rx stream and the lookup pulse cannot be stalled.
// master: drives the rx stream, local_ip and the lookup request; observes status.
// slave : the resolver; drives arp_request, resolved_mac/valid, resolve_fail,
//         busy and rx_frame_ok.
interface arp_reply_resolver_if;
  logic        rx_enable;
  logic [7:0]  rx_data;
  logic [31:0] local_ip;
  logic [31:0] lookup_ip;
  logic        lookup_start;
  logic        arp_request;
  logic [47:0] resolved_mac;
  logic        resolved_valid;
  logic        resolve_fail;
  logic        busy;
  logic        rx_frame_ok;

  modport master (
    output rx_enable, rx_data, local_ip, lookup_ip, lookup_start,
    input  arp_request, resolved_mac, resolved_valid, resolve_fail, busy, rx_frame_ok
  );

  modport slave (
    input  rx_enable, rx_data, local_ip, lookup_ip, lookup_start,
    output arp_request, resolved_mac, resolved_valid, resolve_fail, busy, rx_frame_ok
  );
endinterface

// File: rtl/arp_reply_resolver.sv
// Resolves an IP to a MAC: issues ARP requests with timeout/retry, parses replies.
// Latency: rx_frame_ok and resolved_valid one cycle after the last reply byte; arp_request one cycle after its cause.
// Backpressure: none; the rx stream is consumed at line rate, arp_request is a fire-and-forget pulse.
// Ports: rx_clock (rising edge), reset (synchronous, active-high), bus (slave modport,
//        see arp_reply_resolver_if). Requires TIMEOUT_CYCLES >= 2.
module arp_reply_resolver #(
  parameter int TIMEOUT_CYCLES = 1250000,
  parameter int MAX_RETRIES    = 3
) (
  input logic                 rx_clock,
  input logic                 reset,
  arp_reply_resolver_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_PRE  = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_RX   = 2'd1;
  localparam logic [1:0] P_ERR  = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_OK   = 2'd2;
  localparam logic [1:0] R_FAIL = 2'd3;

  logic [1:0]    p_state;
  logic [4:0]    idx;
  logic [4:0]    idx_cur;
  logic [47:0]   sender_mac;
  logic [31:0]   sender_ip;
  logic [7:0]    exp_byte;
  logic          check_byte;
  logic          byte_ok;
  logic          frame_last;

  logic [1:0]    r_state;
  logic [31:0]   target_ip;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic          reply_match;

  // In P_IDLE the byte on the wire is index 0 of a new frame.
  assign idx_cur = (p_state == P_IDLE) ? 5'd0 : idx;

  always_comb begin
    exp_byte   = 8'h00;
    check_byte = 1'b1;
    case (idx_cur)
      5'd0:    exp_byte = 8'h08;
      5'd1:    exp_byte = 8'h06;
      5'd2:    exp_byte = 8'h00;
      5'd3:    exp_byte = 8'h01;
      5'd4:    exp_byte = 8'h08;
      5'd5:    exp_byte = 8'h00;
      5'd6:    exp_byte = 8'h06;
      5'd7:    exp_byte = 8'h04;
      5'd8:    exp_byte = 8'h00;
      5'd9:    exp_byte = 8'h02;
      5'd26:   exp_byte = bus.local_ip[31:24];
      5'd27:   exp_byte = bus.local_ip[23:16];
      5'd28:   exp_byte = bus.local_ip[15:8];
      5'd29:   exp_byte = bus.local_ip[7:0];
      default: check_byte = 1'b0;
    endcase
    byte_ok = !check_byte || (bus.rx_data == exp_byte);
  end

  // Last byte of a well-formed reply is on the wire this cycle.
  assign frame_last  = bus.rx_enable && (p_state != P_ERR) && (idx_cur == 5'd29) && byte_ok;
  assign reply_match = frame_last && (sender_ip == target_ip);

  // Parser. After a good frame the parser parks in P_ERR so trailing bytes are
  // dropped until rx_enable falls, exactly like a rejected frame.
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      p_state         <= P_IDLE;
      idx             <= 5'd0;
      sender_mac      <= 48'd0;
      sender_ip       <= 32'd0;
      bus.rx_frame_ok <= 1'b0;
    end else begin
      bus.rx_frame_ok <= 1'b0;
      if (bus.rx_enable && (p_state != P_ERR)) begin
        if (idx_cur >= 5'd10 && idx_cur <= 5'd15)
          sender_mac <= {sender_mac[39:0], bus.rx_data};
        if (idx_cur >= 5'd16 && idx_cur <= 5'd19)
          sender_ip <= {sender_ip[23:0], bus.rx_data};
      end
      case (p_state)
        P_IDLE, P_RX: begin
          if (!bus.rx_enable) begin
            p_state <= P_IDLE;
          end else if (!byte_ok) begin
            p_state <= P_ERR;
          end else if (idx_cur == 5'd29) begin
            p_state         <= P_ERR;
            bus.rx_frame_ok <= 1'b1;
          end else begin
            p_state <= P_RX;
            idx     <= idx_cur + 5'd1;
          end
        end
        default: begin
          if (!bus.rx_enable)
            p_state <= P_IDLE;
        end
      endcase
    end
  end

  // Resolver. A retry's request is issued from the cycle the timer sits at its
  // terminal count; the final window instead registers resolve_fail on the edge
  // where the timer reaches that count, so it ends one cycle earlier.
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      r_state            <= R_IDLE;
      target_ip          <= 32'd0;
      timer              <= '0;
      retry              <= '0;
      bus.arp_request    <= 1'b0;
      bus.resolved_mac   <= 48'd0;
      bus.resolved_valid <= 1'b0;
      bus.resolve_fail   <= 1'b0;
    end else begin
      bus.arp_request <= 1'b0;
      if (bus.lookup_start) begin
        target_ip          <= bus.lookup_ip;
        timer              <= '0;
        retry              <= '0;
        bus.resolved_valid <= 1'b0;
        bus.resolve_fail   <= 1'b0;
        bus.arp_request    <= 1'b1;
        r_state            <= R_WAIT;
      end else if (r_state == R_WAIT) begin
        if (reply_match) begin
          // A match beats a simultaneous timeout: no further request.
          bus.resolved_mac   <= sender_mac;
          bus.resolved_valid <= 1'b1;
          r_state            <= R_OK;
        end else if (timer == T_LAST && retry < R_MAX) begin
          retry           <= retry + 1'b1;
          timer           <= '0;
          bus.arp_request <= 1'b1;
        end else if (timer == T_PRE && retry == R_MAX) begin
          bus.resolve_fail <= 1'b1;
          r_state          <= R_FAIL;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  assign bus.busy = (r_state == R_WAIT);

endmodule

// File: tb/tb_arp_reply_resolver.sv
// Self-checking bench for arp_reply_resolver (TIMEOUT_CYCLES=100, MAX_RETRIES=2).
// Latency: n/a. Backpressure: n/a.
// A negedge monitor logs arp_request times and rx_frame_ok observations; each test
// pushes expected reply outcomes and compares them against the logged ones.
module tb_arp_reply_resolver;
  localparam int TO  = 100;
  localparam int MR  = 2;
  localparam logic [31:0] LOCAL_IP = 32'hC0A80164;
  localparam logic [47:0] MAC_A    = 48'h001CC0A2225D;

  logic rx_clock = 1'b0;
  logic reset    = 1'b1;
  int   cyc      = 0;
  int   n_pass   = 0;
  int   n_total  = 0;

  logic [48:0] exp_q[$];
  logic [48:0] obs_q[$];
  int          arp_times[$];
  logic [47:0] exp_mac = 48'd0;

  arp_reply_resolver_if bus();

  arp_reply_resolver #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .rx_clock (rx_clock),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 rx_clock = ~rx_clock;
  always @(posedge rx_clock) cyc++;

  always @(negedge rx_clock) begin
    if (bus.arp_request) arp_times.push_back(cyc);
    if (bus.rx_frame_ok) obs_q.push_back({bus.resolved_valid, bus.resolved_mac});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] fbyte(int i, logic [47:0] mac, logic [31:0] sip,
                                       logic [31:0] tip, logic [15:0] oper);
    logic [239:0] f;
    f = {16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, oper, mac, sip, 48'hFFEEDDCCBBAA, tip};
    return f[239 - 8*i -: 8];
  endfunction

  // Called at a negedge; returns at the next negedge with c0 = cycle of the sampling edge.
  task automatic do_lookup(input logic [31:0] ip, output int c0);
    bus.lookup_ip    = ip;
    bus.lookup_start = 1'b1;
    @(negedge rx_clock);
    c0 = cyc;
    bus.lookup_start = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] mac, input logic [31:0] sip, input logic [31:0] tip,
                            input logic [15:0] oper, input int drop_at, input int reset_at);
    for (int i = 0; i < 30; i++) begin
      if (i == drop_at) break;
      bus.rx_enable = 1'b1;
      bus.rx_data   = fbyte(i, mac, sip, tip, oper);
      if (reset_at >= 0) reset = (i == reset_at);
      @(negedge rx_clock);
    end
    bus.rx_enable = 1'b0;
    bus.rx_data   = 8'h00;
    reset         = 1'b0;
    repeat (2) @(negedge rx_clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge rx_clock);
    n_total++; if (bus.arp_request !== 1'b0) $display("FAIL reset_arp: got %b want 0", bus.arp_request); else n_pass++;
    n_total++; if (bus.resolved_mac !== 48'd0) $display("FAIL reset_mac: got %h want 0", bus.resolved_mac); else n_pass++;
    n_total++; if (bus.resolved_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.resolved_valid); else n_pass++;
    n_total++; if (bus.resolve_fail !== 1'b0) $display("FAIL reset_fail: got %b want 0", bus.resolve_fail); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.rx_frame_ok !== 1'b0) $display("FAIL reset_fok: got %b want 0", bus.rx_frame_ok); else n_pass++;
    reset = 1'b0;
    @(negedge rx_clock);
  endtask

  task automatic test_resolve;
    int c0;
    logic [48:0] e, o;
    arp_times.delete(); obs_q.delete(); exp_q.delete();
    do_lookup(32'hC0A80101, c0);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL resolve_busy_wait: got %b want 1", bus.busy); else n_pass++;
    repeat (3) @(negedge rx_clock);
    exp_q.push_back({1'b1, MAC_A});
    exp_mac = MAC_A;
    send_frame(MAC_A, 32'hC0A80101, LOCAL_IP, 16'h0002, -1, -1);
    n_total++; if (arp_times.size() !== 1) $display("FAIL resolve_arp_count: got %0d want 1", arp_times.size()); else n_pass++;
    n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL resolve_fok_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++; if (o !== e) $display("FAIL resolve_fok_status: got %h want %h", o, e); else n_pass++;
    end
    n_total++; if (bus.resolved_mac !== MAC_A) $display("FAIL resolve_mac: got %h want %h", bus.resolved_mac, MAC_A); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL resolve_busy: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_timeout;
    int c0;
    int t_fail;
    arp_times.delete(); obs_q.delete(); exp_q.delete();
    do_lookup(32'hC0A80101, c0);
    t_fail = -1;
    for (int k = 0; k < 400; k++) begin
      if (bus.resolve_fail === 1'b1) begin
        t_fail = cyc - c0 + 1;
        break;
      end
      @(negedge rx_clock);
    end
    n_total++; if (t_fail !== MR * TO + TO - 1 + 1) $display("FAIL timeout_fail_time: got %0d want %0d", t_fail, MR * TO + TO); else n_pass++;
    n_total++; if (arp_times.size() !== MR + 1) $display("FAIL timeout_arp_count: got %0d want %0d", arp_times.size(), MR + 1); else n_pass++;
    for (int k = 0; k <= MR && k < arp_times.size(); k++) begin
      n_total++;
      if (arp_times[k] - c0 + 1 !== 1 + k * TO)
        $display("FAIL timeout_arp_time%0d: got %0d want %0d", k, arp_times[k] - c0 + 1, 1 + k * TO);
      else n_pass++;
    end
    n_total++; if (bus.busy !== 1'b0) $display("FAIL timeout_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.resolved_valid !== 1'b0) $display("FAIL timeout_valid: got %b want 0", bus.resolved_valid); else n_pass++;
    n_total++; if (bus.resolved_mac !== exp_mac) $display("FAIL timeout_mac_kept: got %h want %h", bus.resolved_mac, exp_mac); else n_pass++;
    repeat (150) @(negedge rx_clock);
    n_total++; if (arp_times.size() !== MR + 1) $display("FAIL timeout_no_extra_arp: got %0d want %0d", arp_times.size(), MR + 1); else n_pass++;
    n_total++; if (bus.resolve_fail !== 1'b1) $display("FAIL timeout_fail_hold: got %b want 1", bus.resolve_fail); else n_pass++;
  endtask

  task automatic test_bad_frames;
    int c0;
    logic [47:0] mac_b;
    logic [48:0] e, o;
    mac_b = 48'h02AABBCCDDEE;
    arp_times.delete(); obs_q.delete(); exp_q.delete();
    do_lookup(32'hC0A80101, c0);
    send_frame(mac_b, 32'hC0A80101, LOCAL_IP, 16'h0001, -1, -1);
    n_total++; if (obs_q.size() !== 0) $display("FAIL bad_oper_fok: got %0d want 0", obs_q.size()); else n_pass++;
    send_frame(mac_b, 32'hC0A80101, 32'hC0A80165, 16'h0002, -1, -1);
    n_total++; if (obs_q.size() !== 0) $display("FAIL bad_tip_fok: got %0d want 0", obs_q.size()); else n_pass++;
    send_frame(mac_b, 32'hC0A80101, LOCAL_IP, 16'h0002, 20, -1);
    n_total++; if (obs_q.size() !== 0) $display("FAIL bad_short_fok: got %0d want 0", obs_q.size()); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL bad_busy: got %b want 1", bus.busy); else n_pass++;
    n_total++; if (bus.resolved_valid !== 1'b0) $display("FAIL bad_valid: got %b want 0", bus.resolved_valid); else n_pass++;
    // Parser must have recovered: a good reply now resolves.
    exp_q.push_back({1'b1, mac_b});
    exp_mac = mac_b;
    send_frame(mac_b, 32'hC0A80101, LOCAL_IP, 16'h0002, -1, -1);
    n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL bad_recover_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++; if (o !== e) $display("FAIL bad_recover_status: got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_mismatch;
    int c0;
    logic [48:0] e, o;
    arp_times.delete(); obs_q.delete(); exp_q.delete();
    do_lookup(32'hC0A80101, c0);
    repeat (2) @(negedge rx_clock);
    exp_q.push_back({1'b0, exp_mac});
    send_frame(48'h0A0B0C0D0E0F, 32'hC0A80102, LOCAL_IP, 16'h0002, -1, -1);
    n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL mismatch_fok_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++; if (o !== e) $display("FAIL mismatch_fok_status: got %h want %h", o, e); else n_pass++;
    end
    for (int k = 0; k < 150; k++) begin
      if (arp_times.size() >= 2) break;
      @(negedge rx_clock);
    end
    n_total++; if (arp_times.size() !== 2) $display("FAIL mismatch_retry: got %0d arp want 2", arp_times.size()); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL mismatch_busy: got %b want 1", bus.busy); else n_pass++;
    n_total++; if (bus.resolved_valid !== 1'b0) $display("FAIL mismatch_valid: got %b want 0", bus.resolved_valid); else n_pass++;
  endtask

  task automatic test_match_on_timeout;
    int c0;
    logic [47:0] mac_c;
    logic [48:0] e, o;
    mac_c = 48'h112233445566;
    arp_times.delete(); obs_q.delete(); exp_q.delete();
    do_lookup(32'hC0A80101, c0);
    // Byte 0 sampled on edge c0+71, so byte 29 lands on edge c0+100, the first timeout.
    repeat (70) @(negedge rx_clock);
    exp_q.push_back({1'b1, mac_c});
    exp_mac = mac_c;
    send_frame(mac_c, 32'hC0A80101, LOCAL_IP, 16'h0002, -1, -1);
    repeat (150) @(negedge rx_clock);
    n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL edge_fok_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_total++; if (o !== e) $display("FAIL edge_fok_status: got %h want %h", o, e); else n_pass++;
    end
    n_total++; if (arp_times.size() !== 1) $display("FAIL edge_arp_count: got %0d want 1", arp_times.size()); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL edge_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.resolve_fail !== 1'b0) $display("FAIL edge_fail: got %b want 0", bus.resolve_fail); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int c0;
    arp_times.delete(); obs_q.delete(); exp_q.delete();
    do_lookup(32'hC0A80101, c0);
    repeat (2) @(negedge rx_clock);
    send_frame(MAC_A, 32'hC0A80101, LOCAL_IP, 16'h0002, -1, 15);
    exp_mac = 48'd0;
    n_total++; if (obs_q.size() !== 0) $display("FAIL rstmid_fok: got %0d want 0", obs_q.size()); else n_pass++;
    n_total++; if (bus.resolved_mac !== exp_mac) $display("FAIL rstmid_mac: got %h want %h", bus.resolved_mac, exp_mac); else n_pass++;
    n_total++; if (bus.resolved_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bus.resolved_valid); else n_pass++;
    n_total++; if (bus.resolve_fail !== 1'b0) $display("FAIL rstmid_fail: got %b want 0", bus.resolve_fail); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else n_pass++;
    repeat (150) @(negedge rx_clock);
    n_total++; if (arp_times.size() !== 1) $display("FAIL rstmid_arp: got %0d want 1", arp_times.size()); else n_pass++;
  endtask

  initial begin
    bus.rx_enable    = 1'b0;
    bus.rx_data      = 8'h00;
    bus.local_ip     = LOCAL_IP;
    bus.lookup_ip    = 32'd0;
    bus.lookup_start = 1'b0;
    @(negedge rx_clock);
    test_reset();
    test_resolve();
    test_timeout();
    test_bad_frames();
    test_mismatch();
    test_match_on_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
